// File: rtl/genius_pacer_if.sv
// Request/pulse bus between the Genius game FSM (master) and the pacer (slave).
// Raw buttons ride on the same bus so the pacer sees one bundle.
interface genius_pacer_if;
  logic       show_req;
  logic [4:0] show_len;
  logic       input_req;
  logic       input_abort;
  logic [1:0] speed_sel;
  logic [2:0] btn;
  logic [3:0] show_idx;
  logic       show_on;
  logic       show_done;
  logic       btn_valid;
  logic [1:0] btn_code;
  logic       input_done;
  logic       timeout;
  logic       busy;

  modport master (
    output show_req, show_len, input_req, input_abort, speed_sel, btn,
    input  show_idx, show_on, show_done, btn_valid, btn_code, input_done, timeout, busy
  );

  modport slave (
    input  show_req, show_len, input_req, input_abort, speed_sel, btn,
    output show_idx, show_on, show_done, btn_valid, btn_code, input_done, timeout, busy
  );
endinterface

// File: rtl/genius_pacer.sv
// Show-phase pacing and debounced player-input window for the Genius game.
// All durations are counted in prescaled ticks; the prescaler restarts on every state change.
module genius_pacer #(
  parameter int TICK_DIV      = 50000,
  parameter int ON_TICKS      = 400,
  parameter int GAP_TICKS     = 200,
  parameter int DEB_TICKS     = 20,
  parameter int TIMEOUT_TICKS = 5000
) (
  input  logic           clock,
  input  logic           reset,
  genius_pacer_if.slave  bus
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int PH_MAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int DB_W   = $clog2(DEB_TICKS + 1);
  localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DEB_LAST = DB_W'(DEB_TICKS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHOW_ON,
    SHOW_GAP,
    WAIT_PRESS,
    WAIT_RELEASE
  } state_t;

  state_t            state;
  logic [PRE_W-1:0]  pre;
  logic [PH_W-1:0]   ph_cnt;
  logic [PH_W-1:0]   dur;
  logic [DB_W-1:0]   deb_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [4:0]        len;
  logic [4:0]        presses;
  logic [2:0]        btn_s1;
  logic [2:0]        btn_s2;

  logic [3:0]        show_idx_r;
  logic              show_on_r;
  logic              show_done_r;
  logic              btn_valid_r;
  logic [1:0]        btn_code_r;
  logic              input_done_r;
  logic              timeout_r;
  logic              busy_r;

  logic              tick;
  logic              btn_nz;

  assign tick   = (pre == PRE_LAST);
  assign btn_nz = |btn_s2;

  assign bus.show_idx   = show_idx_r;
  assign bus.show_on    = show_on_r;
  assign bus.show_done  = show_done_r;
  assign bus.btn_valid  = btn_valid_r;
  assign bus.btn_code   = btn_code_r;
  assign bus.input_done = input_done_r;
  assign bus.timeout    = timeout_r;
  assign bus.busy       = busy_r;

  function automatic logic [4:0] clamp_len(input logic [4:0] l);
    if (l == 5'd0)  return 5'd1;
    if (l > 5'd16)  return 5'd16;
    return l;
  endfunction

  // Scaled phase length, never shorter than one tick.
  function automatic logic [PH_W-1:0] scaled_dur(input int base, input logic [1:0] sel);
    int s;
    s = base >> sel;
    if (s < 1) s = 1;
    return PH_W'(s);
  endfunction

  function automatic logic [1:0] btn_encode(input logic [2:0] b);
    case (b)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Buttons are asynchronous; only btn_s2 is used downstream.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      btn_s1 <= bus.btn;
      btn_s2 <= btn_s1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pre          <= '0;
      ph_cnt       <= '0;
      dur          <= '0;
      deb_cnt      <= '0;
      to_cnt       <= '0;
      len          <= '0;
      presses      <= '0;
      show_idx_r   <= '0;
      show_on_r    <= 1'b0;
      show_done_r  <= 1'b0;
      btn_valid_r  <= 1'b0;
      btn_code_r   <= '0;
      input_done_r <= 1'b0;
      timeout_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      show_done_r  <= 1'b0;
      btn_valid_r  <= 1'b0;
      input_done_r <= 1'b0;
      timeout_r    <= 1'b0;
      pre          <= tick ? '0 : pre + 1'b1;

      case (state)
        IDLE: begin
          pre <= '0;
          if (bus.show_req) begin
            len        <= clamp_len(bus.show_len);
            show_idx_r <= '0;
            ph_cnt     <= '0;
            dur        <= scaled_dur(ON_TICKS, bus.speed_sel);
            show_on_r  <= 1'b1;
            busy_r     <= 1'b1;
            state      <= SHOW_ON;
          end else if (bus.input_req) begin
            len     <= clamp_len(bus.show_len);
            presses <= '0;
            deb_cnt <= '0;
            to_cnt  <= '0;
            busy_r  <= 1'b1;
            state   <= WAIT_PRESS;
          end
        end

        SHOW_ON: begin
          if (tick) begin
            if (ph_cnt == dur - 1'b1) begin
              ph_cnt    <= '0;
              dur       <= scaled_dur(GAP_TICKS, bus.speed_sel);
              show_on_r <= 1'b0;
              pre       <= '0;
              state     <= SHOW_GAP;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
        end

        SHOW_GAP: begin
          if (tick) begin
            if (ph_cnt == dur - 1'b1) begin
              ph_cnt <= '0;
              pre    <= '0;
              if ({1'b0, show_idx_r} == len - 5'd1) begin
                show_done_r <= 1'b1;
                busy_r      <= 1'b0;
                state       <= IDLE;
              end else begin
                show_idx_r <= show_idx_r + 1'b1;
                dur        <= scaled_dur(ON_TICKS, bus.speed_sel);
                show_on_r  <= 1'b1;
                state      <= SHOW_ON;
              end
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end
        end

        // A completed press outranks both abort and timeout in the same cycle.
        WAIT_PRESS: begin
          if (btn_nz && tick && deb_cnt == DEB_LAST) begin
            btn_valid_r <= 1'b1;
            btn_code_r  <= btn_encode(btn_s2);
            presses     <= presses + 5'd1;
            to_cnt      <= '0;
            deb_cnt     <= '0;
            pre         <= '0;
            if (bus.input_abort) begin
              busy_r <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= WAIT_RELEASE;
            end
          end else if (bus.input_abort) begin
            pre    <= '0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            if (!btn_nz)   deb_cnt <= '0;
            else if (tick) deb_cnt <= deb_cnt + 1'b1;
            if (tick) begin
              if (to_cnt == TO_LAST) begin
                timeout_r <= 1'b1;
                pre       <= '0;
                busy_r    <= 1'b0;
                state     <= IDLE;
              end else begin
                to_cnt <= to_cnt + 1'b1;
              end
            end
          end
        end

        WAIT_RELEASE: begin
          if (bus.input_abort) begin
            pre    <= '0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (btn_nz) begin
            deb_cnt <= '0;
          end else if (tick) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt <= '0;
              pre     <= '0;
              if (presses == len) begin
                input_done_r <= 1'b1;
                busy_r       <= 1'b0;
                state        <= IDLE;
              end else begin
                state <= WAIT_PRESS;
              end
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
        end

        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_genius_pacer.sv
// Randomized scenario bench for genius_pacer; expectations come from duration
// arithmetic and press lists, not from a copy of the state machine.
module tb_genius_pacer;

  localparam int TD  = 4;
  localparam int ONT = 8;
  localparam int GPT = 4;
  localparam int DBT = 2;
  localparam int TOT = 20;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  genius_pacer_if bus ();

  genius_pacer #(
    .TICK_DIV      (TD),
    .ON_TICKS      (ONT),
    .GAP_TICKS     (GPT),
    .DEB_TICKS     (DBT),
    .TIMEOUT_TICKS (TOT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  int ev_valid, ev_idone, ev_to, ev_sdone;
  logic [1:0] codes[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
    if (bus.btn_valid === 1'b1) begin
      ev_valid++;
      codes.push_back(bus.btn_code);
    end
    if (bus.input_done === 1'b1) ev_idone++;
    if (bus.timeout === 1'b1)    ev_to++;
    if (bus.show_done === 1'b1)  ev_sdone++;
  endtask

  task automatic clear_events();
    ev_valid = 0; ev_idone = 0; ev_to = 0; ev_sdone = 0;
    codes.delete();
  endtask

  function automatic int model_len(input int l);
    if (l == 0) return 1;
    if (l > 16) return 16;
    return l;
  endfunction

  function automatic int model_cycles(input int base, input int spd);
    int t;
    t = base >> spd;
    if (t < 1) t = 1;
    return t * TD;
  endfunction

  function automatic logic [1:0] model_code(input logic [2:0] b);
    if (b == 3'b001) return 2'd0;
    if (b == 3'b010) return 2'd1;
    if (b == 3'b100) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [11:0] all_outs();
    return {bus.show_idx, bus.show_on, bus.show_done, bus.btn_valid,
            bus.btn_code, bus.input_done, bus.timeout, bus.busy};
  endfunction

  // Per-cycle comparison of {busy, show_done, show_on, show_idx} over a whole show.
  task automatic run_show(input int raw_len, input int spd, input bit with_input);
    int L, on_c, gap_c, per, total, item, ph;
    logic [6:0] exp_v, got_v;
    L     = model_len(raw_len);
    on_c  = model_cycles(ONT, spd);
    gap_c = model_cycles(GPT, spd);
    per   = on_c + gap_c;
    total = L * per;
    clear_events();
    bus.speed_sel = 2'(spd);
    bus.show_len  = 5'(raw_len);
    bus.show_req  = 1'b1;
    bus.input_req = with_input;
    step();
    bus.show_req  = 1'b0;
    bus.input_req = 1'b0;
    for (int j = 0; j <= total; j++) begin
      if (j < total) begin
        item  = j / per;
        ph    = j % per;
        exp_v = {1'b1, 1'b0, (ph < on_c), 4'(item)};
      end else begin
        exp_v = {1'b0, 1'b1, 1'b0, 4'(L - 1)};
      end
      got_v = {bus.busy, bus.show_done, bus.show_on, bus.show_idx};
      check($sformatf("show len=%0d spd=%0d cyc=%0d", raw_len, spd, j), 32'(got_v), 32'(exp_v));
      if (j < total) step();
    end
    step();
    check("show_done one cycle", 32'(bus.show_done), 32'd0);
    check("show idle after done", 32'(bus.busy), 32'd0);
    check("show_done count", 32'(ev_sdone), 32'd1);
  endtask

  // Presses with optional short bounce; holds are long enough for any prescaler phase.
  task automatic run_input(input int L, input bit bounce);
    logic [2:0] pats [7] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110, 3'b111};
    logic [2:0] b;
    logic [1:0] exp_codes[$];
    clear_events();
    bus.show_len  = 5'(L);
    bus.input_req = 1'b1;
    step();
    bus.input_req = 1'b0;
    for (int p = 0; p < L; p++) begin
      b = pats[$urandom_range(0, 6)];
      exp_codes.push_back(model_code(b));
      if (bounce) begin
        bus.btn = b;
        repeat ($urandom_range(1, 4)) step();
        bus.btn = 3'b000;
        repeat (6) step();
      end
      bus.btn = b;
      repeat (16 + $urandom_range(0, 8)) step();
      bus.btn = 3'b000;
      repeat (16 + $urandom_range(0, 8)) step();
    end
    repeat (4) step();
    check($sformatf("press count L=%0d", L), 32'(ev_valid), 32'(L));
    for (int i = 0; i < L; i++)
      if (i < codes.size())
        check($sformatf("press code #%0d", i), 32'(codes[i]), 32'(exp_codes[i]));
    check("input_done count", 32'(ev_idone), 32'd1);
    check("no timeout in window", 32'(ev_to), 32'd0);
    check("idle after input", 32'(bus.busy), 32'd0);
    check("btn_code held", 32'(bus.btn_code), 32'(exp_codes[L-1]));
  endtask

  initial begin
    int k;
    reset           = 1'b0;
    bus.show_req    = 1'b0;
    bus.show_len    = 5'd0;
    bus.input_req   = 1'b0;
    bus.input_abort = 1'b0;
    bus.speed_sel   = 2'd0;
    bus.btn         = 3'b000;
    clear_events();
    repeat (3) @(posedge clock);
    #1;
    check("reset outputs", 32'(all_outs()), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step();
    check("idle after reset", 32'(all_outs()), 32'd0);

    // Show pacing and speed scaling, directed then random.
    run_show(3, 0, 1'b0);
    run_show(1, 3, 1'b0);
    run_show(0, 1, 1'b0);
    run_show(20, 2, 1'b0);
    for (int i = 0; i < 6; i++)
      run_show($urandom_range(0, 20), $urandom_range(0, 3), 1'b0);

    // Debounce with bounce: buttons 010 then 001.
    clear_events();
    bus.show_len  = 5'd2;
    bus.input_req = 1'b1;
    step();
    bus.input_req = 1'b0;
    bus.btn = 3'b010; repeat (4) step();
    bus.btn = 3'b000; repeat (6) step();
    check("no pulse on bounce", 32'(ev_valid), 32'd0);
    bus.btn = 3'b010; repeat (20) step();
    bus.btn = 3'b000; repeat (20) step();
    bus.btn = 3'b001; repeat (20) step();
    check("no input_done before release", 32'(ev_idone), 32'd0);
    bus.btn = 3'b000; repeat (20) step();
    check("directed press count", 32'(ev_valid), 32'd2);
    if (codes.size() == 2) begin
      check("directed code 1", 32'(codes[0]), 32'd1);
      check("directed code 2", 32'(codes[1]), 32'd0);
    end
    check("directed input_done", 32'(ev_idone), 32'd1);

    for (int i = 0; i < 6; i++)
      run_input($urandom_range(1, 4), 1'($urandom_range(0, 1)));

    // Multi-press code and abort while held.
    clear_events();
    bus.show_len  = 5'd2;
    bus.input_req = 1'b1;
    step();
    bus.input_req = 1'b0;
    bus.btn = 3'b101; repeat (20) step();
    check("multi press valid", 32'(ev_valid), 32'd1);
    check("multi press code", 32'(bus.btn_code), 32'd3);
    check("busy before abort", 32'(bus.busy), 32'd1);
    bus.input_abort = 1'b1;
    step();
    bus.input_abort = 1'b0;
    check("busy after abort", 32'(bus.busy), 32'd0);
    bus.btn = 3'b000; repeat (30) step();
    check("no input_done after abort", 32'(ev_idone), 32'd0);
    check("no extra press after abort", 32'(ev_valid), 32'd1);

    // Inactivity timeout.
    clear_events();
    bus.show_len  = 5'd1;
    bus.input_req = 1'b1;
    step();
    bus.input_req = 1'b0;
    k = 0;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (bus.timeout === 1'b1) begin
        k = c;
        break;
      end
    end
    check("timeout latency", 32'(k), 32'd80);
    check("busy at timeout", 32'(bus.busy), 32'd0);
    step();
    check("timeout one cycle", 32'(bus.timeout), 32'd0);

    // Held button never times out.
    clear_events();
    bus.show_len  = 5'd2;
    bus.input_req = 1'b1;
    step();
    bus.input_req = 1'b0;
    bus.btn = 3'b100; repeat (120) step();
    check("held press valid", 32'(ev_valid), 32'd1);
    check("held press code", 32'(bus.btn_code), 32'd2);
    check("no timeout while held", 32'(ev_to), 32'd0);
    check("busy while held", 32'(bus.busy), 32'd1);
    bus.btn = 3'b000; repeat (20) step();
    bus.input_abort = 1'b1;
    step();
    bus.input_abort = 1'b0;
    check("abort in wait_press", 32'(bus.busy), 32'd0);
    check("abort no pulses", 32'(ev_idone + ev_to), 32'd0);

    // Asynchronous reset in the middle of SHOW_ON.
    bus.speed_sel = 2'd0;
    bus.show_len  = 5'd5;
    bus.show_req  = 1'b1;
    step();
    bus.show_req  = 1'b0;
    repeat (10) step();
    check("show_on before reset", 32'(bus.show_on), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async reset outputs", 32'(all_outs()), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Simultaneous requests: only the show runs, no input window afterwards.
    run_show(2, 3, 1'b1);
    clear_events();
    repeat (30) step();
    check("no input window after show", 32'(bus.busy), 32'd0);
    check("no input pulses", 32'(ev_valid + ev_idone + ev_to), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/genius_pacer.md
Name: genius_pacer

Overview:
- Timing and input scheduler for the Genius game FSM.
- Paces the show phase: sequence index, display-visible window, inter-item gap.
- Owns the player-input window: debounced one-shot button events and inactivity timeout.
- The game FSM only issues requests and consumes pulses, so it no longer advances once per clock.

Parameters:
TICK_DIV, 50000, clock cycles per time tick (1 ms at 50 MHz); must be >= 2
ON_TICKS, 400, ticks an item is visible at speed_sel=0
GAP_TICKS, 200, ticks of blank gap after each item at speed_sel=0
DEB_TICKS, 20, ticks the button state must be stable to count as press or release
TIMEOUT_TICKS, 5000, ticks without a valid press before timeout fires

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
show_req  input  1  one-cycle pulse: start showing show_len items
show_len  input  5  items to show, 1..16; 0 treated as 1, >16 clamped to 16
input_req  input  1  one-cycle pulse: open input window for show_len presses
input_abort  input  1  game detected wrong press; close window immediately
speed_sel  input  2  duration divisor: on/gap time = base >> speed_sel (minimum 1 tick)
btn  input  3  raw push buttons, active-high, asynchronous to clock
show_idx  output  4  index of item currently shown (0-based)
show_on  output  1  high while item show_idx must be displayed
show_done  output  1  one-cycle pulse after last gap ends
btn_valid  output  1  one-cycle pulse per accepted press
btn_code  output  2  btn[0]->0, btn[1]->1, btn[2]->2, more than one pressed->3; held until next btn_valid
input_done  output  1  one-cycle pulse when show_len presses accepted
timeout  output  1  one-cycle pulse on inactivity timeout
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; all counters 0; synchronizer flops 0.
- btn passes through a 2-flop synchronizer; the debouncer sees the synchronized value only.
- Prescaler: counts 0..TICK_DIV-1 and emits a tick on the terminal count. It restarts at 0 on every state transition, so phase durations are exact multiples of TICK_DIV cycles.
- Durations are latched on state entry: on=max(ON_TICKS>>speed_sel,1), gap=max(GAP_TICKS>>speed_sel,1). A speed_sel change mid-phase takes effect at the next phase.
- Length latched on request: len = clamp(show_len).
- IDLE:
  - show_req -> SHOW_ON, show_idx=0.
  - else input_req -> WAIT_PRESS, press count=0.
  - show_req and input_req in the same cycle: show wins, input_req is dropped.
- SHOW_ON: show_on=1. After `on` ticks -> SHOW_GAP.
- SHOW_GAP: show_on=0. After `gap` ticks:
  - show_idx==len-1 -> pulse show_done, IDLE, show_idx holds.
  - else show_idx+1, -> SHOW_ON.
- WAIT_PRESS:
  - Synchronized btn != 0 for DEB_TICKS consecutive ticks -> pulse btn_valid, update btn_code, count+1, -> WAIT_RELEASE.
  - A bounce back to 0 restarts the debounce count.
  - The inactivity counter advances each tick and clears on btn_valid. Reaching TIMEOUT_TICKS -> pulse timeout, IDLE.
- WAIT_RELEASE:
  - Synchronized btn == 0 for DEB_TICKS consecutive ticks -> either count==len: pulse input_done, IDLE; or otherwise WAIT_PRESS.
  - The inactivity counter is frozen here; a held button never times out.
- Requests (show_req, input_req) arriving while busy=1 are ignored.
- input_abort:
  - In WAIT_PRESS or WAIT_RELEASE it forces IDLE next cycle with no pulses.
  - The same cycle as a btn_valid event: btn_valid still pulses, then IDLE.
  - Ignored in other states.
- Timeout coinciding with debounce completion: the press wins, btn_valid pulses, no timeout.
- Pulses (show_done, btn_valid, input_done, timeout) last exactly one cycle and are registered. Latency from the qualifying tick to the pulse is 1 cycle.
- Counter widths sized by $clog2 of each parameter; no wrap is possible within legal ranges.

Test Plan:
All tests use TICK_DIV=4, ON_TICKS=8, GAP_TICKS=4, DEB_TICKS=2, TIMEOUT_TICKS=20.

1. Show pacing: reset release, show_req with show_len=3, speed_sel=0 -> show_on high 32 cycles / low 16 cycles ×3, show_idx 0,1,2, show_done 1 cycle after the 3rd gap, 144 cycles total.
2. Speed scaling: show_len=1, speed_sel=3 -> on=1 tick (4 cycles), gap=max(4>>3,1)=1 tick; show_done after 8 cycles. show_len=0 shows exactly 1 item.
3. Debounce: input_req, len=2; btn=3'b010 bounces 1 tick then steady; release; btn=3'b001 -> exactly 2 btn_valid pulses, codes 1 then 0, input_done after 2nd release debounce; no pulse on the bounce.
4. Multi-press and abort: btn=3'b101 steady -> btn_valid with btn_code=3. input_abort during WAIT_RELEASE -> busy=0 next cycle, no input_done.
5. Timeout: input_req, no buttons -> timeout pulse after exactly 80 cycles, busy drops. Holding a button >80 cycles after a valid press produces no timeout.
6. Async reset mid-SHOW_ON: reset low asynchronously -> all outputs 0 immediately, state IDLE. Also show_req+input_req in the same cycle -> only show runs.
